// File: rtl/nbody_pkg.sv
// nbody_pkg: shared types and constants for the N-body BRAM datapath.
//   body_t      : {x, y, vx, vy, mass}, 16 bits each, MSB first
//   force_rec_t : {fx[31:0], pad[15:0], fy[31:0]}
//   integ_state_t : body_integrator FSM states
//   sat16       : clamp a 33-bit signed value to 16-bit signed range
package nbody_pkg;

  localparam int BRAM_ADDR_W        = 15;
  localparam int BRAM_RD_LAT        = 2;
  localparam int FORCE_BASE_DEFAULT = 400;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] vx;
    logic signed [15:0] vy;
    logic        [15:0] mass;
  } body_t;

  typedef struct packed {
    logic signed [31:0] fx;
    logic        [15:0] pad;
    logic signed [31:0] fy;
  } force_rec_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_BODY,
    S_WAIT_BODY,
    S_LATCH_BODY,
    S_RD_FORCE,
    S_WAIT_FORCE,
    S_LATCH_FORCE,
    S_COMPUTE,
    S_WRITE,
    S_CLEAR,
    S_NEXT,
    S_DONE
  } integ_state_t;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)
      return 16'sh7fff;
    else if (v < -33'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/euler_update.sv
// euler_update: combinational semi-implicit Euler step, dt = 2^-DT_SHIFT.
//   body      in  : current body
//   force_rec in  : accumulated force record for that body
//   body_next out : updated body (velocity first, then position from the
//                   new velocity), each component saturated to 16 bits
module euler_update
  import nbody_pkg::*;
#(
  parameter int DT_SHIFT = 4
) (
  input  body_t      body,
  input  force_rec_t force_rec,
  output body_t      body_next
);

  logic signed [32:0] fx_ext, fy_ext, vx_sum, vy_sum;
  logic signed [15:0] vx_new, vy_new;
  logic signed [16:0] vxn_ext, vyn_ext, x_sum, y_sum;
  logic               unused_pad;

  assign unused_pad = ^force_rec.pad;

  always_comb begin
    fx_ext  = 33'(force_rec.fx);
    fy_ext  = 33'(force_rec.fy);
    vx_sum  = 33'(body.vx) + (fx_ext >>> DT_SHIFT);
    vy_sum  = 33'(body.vy) + (fy_ext >>> DT_SHIFT);
    vx_new  = sat16(vx_sum);
    vy_new  = sat16(vy_sum);
    vxn_ext = 17'(vx_new);
    vyn_ext = 17'(vy_new);
    x_sum   = 17'(body.x) + (vxn_ext >>> DT_SHIFT);
    y_sum   = 17'(body.y) + (vyn_ext >>> DT_SHIFT);

    body_next.x    = sat16(33'(x_sum));
    body_next.y    = sat16(33'(y_sum));
    body_next.vx   = vx_new;
    body_next.vy   = vy_new;
    body_next.mass = body.mass;
  end

endmodule

// File: rtl/body_integrator.sv
// body_integrator: walks bodies 0..N-1, reads body i and its force record at
// FORCE_BASE+i, applies euler_update and writes the new body back to i.
//   clk, reset (sync, active low), start (sampled in IDLE/DONE only)
//   busy, done            : status
//   mem_addr/wdata/wren   : shared BRAM port (read and write share mem_addr)
//   mem_rdata             : BRAM q, valid 2 cycles after address
// Build option: INTEGRATOR_CLEAR_FORCE_EN inserts a CLEAR state after WRITE
// that zeroes the force record of the body just written.
module body_integrator
  import nbody_pkg::*;
#(
  parameter int N          = 16,
  parameter int FORCE_BASE = FORCE_BASE_DEFAULT,
  parameter int DT_SHIFT   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [BRAM_ADDR_W-1:0] mem_addr,
  output logic [79:0]            mem_wdata,
  output logic                   mem_wren,
  input  logic [79:0]            mem_rdata
);

  localparam int                     CW   = $clog2(N + 1);
  localparam logic [CW-1:0]          LAST = CW'(N - 1);
  localparam logic [BRAM_ADDR_W-1:0] FB   = BRAM_ADDR_W'(FORCE_BASE);

  integ_state_t              state, state_next;
  logic [CW-1:0]             idx;
  body_t                     body_q, result_q, result_d;
  force_rec_t                force_q;
  logic [BRAM_ADDR_W-1:0]    addr_body, addr_force;

  assign addr_body  = BRAM_ADDR_W'(idx);
  assign addr_force = FB + addr_body;

  euler_update #(
    .DT_SHIFT (DT_SHIFT)
  ) u_euler (
    .body      (body_q),
    .force_rec (force_q),
    .body_next (result_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      body_q   <= '0;
      force_q  <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE: if (start) idx <= '0;
        S_LATCH_BODY:   body_q   <= body_t'(mem_rdata);
        S_LATCH_FORCE:  force_q  <= force_rec_t'(mem_rdata);
        S_COMPUTE:      result_q <= result_d;
        S_NEXT:         idx      <= idx + CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wren   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_RD_BODY;
      end
      S_RD_BODY: begin
        mem_addr   = addr_body;
        state_next = S_WAIT_BODY;
      end
      S_WAIT_BODY: begin
        mem_addr   = addr_body;
        state_next = S_LATCH_BODY;
      end
      S_LATCH_BODY: begin
        mem_addr   = addr_body;
        state_next = S_RD_FORCE;
      end
      S_RD_FORCE: begin
        mem_addr   = addr_force;
        state_next = S_WAIT_FORCE;
      end
      S_WAIT_FORCE: begin
        mem_addr   = addr_force;
        state_next = S_LATCH_FORCE;
      end
      S_LATCH_FORCE: begin
        mem_addr   = addr_force;
        state_next = S_COMPUTE;
      end
      S_COMPUTE: state_next = S_WRITE;
      S_WRITE: begin
        mem_addr  = addr_body;
        mem_wren  = 1'b1;
        mem_wdata = result_q;
`ifdef INTEGRATOR_CLEAR_FORCE_EN
        state_next = S_CLEAR;
`else
        state_next = S_NEXT;
`endif
      end
`ifdef INTEGRATOR_CLEAR_FORCE_EN
      S_CLEAR: begin
        mem_addr   = addr_force;
        mem_wren   = 1'b1;
        state_next = S_NEXT;
      end
`endif
      S_NEXT: state_next = (idx < LAST) ? S_RD_BODY : S_DONE;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_next = S_RD_BODY;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_body_integrator.sv
module tb_body_integrator;

  localparam int N  = 16;
  localparam int FB = 400;
  localparam int DT = 4;
`ifdef INTEGRATOR_CLEAR_FORCE_EN
  localparam int P  = 10;
  localparam bit CLR = 1'b1;
`else
  localparam int P  = 9;
  localparam bit CLR = 1'b0;
`endif
  localparam int LIM = 4000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_wren;
  logic [14:0] mem_addr;
  logic [79:0] mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  body_integrator #(
    .N          (N),
    .FORCE_BASE (FB),
    .DT_SHIFT   (DT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // BRAM model: 2-cycle read latency, write on posedge, plus a backdoor port
  logic [79:0] mem [0:1023];
  logic [79:0] rd1, rd2;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [79:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wren) mem[mem_addr[9:0]] <= mem_wdata;
    rd1 <= mem[mem_addr[9:0]];
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  task automatic bd_write(input int a, input logic [79:0] d);
    bd_addr = 10'(a);
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // Reference arithmetic
  function automatic longint fl(longint a);
    longint d, q;
    d = longint'(1) << DT;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint sat(longint a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  function automatic logic [79:0] model_step(logic [79:0] b, logic [79:0] f);
    longint x, y, vx, vy, fx, fy;
    x  = longint'($signed(b[79:64]));
    y  = longint'($signed(b[63:48]));
    vx = longint'($signed(b[47:32]));
    vy = longint'($signed(b[31:16]));
    fx = longint'($signed(f[79:48]));
    fy = longint'($signed(f[31:0]));
    vx = sat(vx + fl(fx));
    vy = sat(vy + fl(fy));
    x  = sat(x + fl(vx));
    y  = sat(y + fl(vy));
    return {16'(x), 16'(y), 16'(vx), 16'(vy), b[15:0]};
  endfunction

  function automatic logic [79:0] mk_body(int x, int y, int vx, int vy, int m);
    return {16'(x), 16'(y), 16'(vx), 16'(vy), 16'(m)};
  endfunction

  function automatic logic [79:0] mk_force(int fx, int fy);
    return {32'(fx), 16'hbeef, 32'(fy)};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-schedule model: mt counts cycles since start was accepted
  bit          mrun = 1'b0;
  bit          mdone = 1'b0;
  int          mt = 0;
  int          pass_no = 0;
  bit          checking = 1'b0;
  logic [79:0] snap_b [N];
  logic [79:0] snap_f [N];

  always @(posedge clk) begin
    if (!reset) begin
      mrun  = 1'b0;
      mdone = 1'b0;
    end else if (mrun) begin
      mt++;
      if (mt > P * N) begin
        mrun  = 1'b0;
        mdone = 1'b1;
      end
    end else if (start) begin
      mrun  = 1'b1;
      mdone = 1'b0;
      mt    = 1;
      for (int k = 0; k < N; k++) begin
        snap_b[k] = mem[k];
        snap_f[k] = mem[FB + k];
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic        e_busy, e_done, e_wren;
      logic [14:0] e_addr;
      logic [79:0] e_wdata;
      int          k, ph;
      e_busy  = mrun;
      e_done  = mdone;
      e_addr  = '0;
      e_wren  = 1'b0;
      e_wdata = '0;
      if (mrun) begin
        k  = (mt - 1) / P;
        ph = (mt - 1) % P;
        if (ph < 3) e_addr = 15'(k);
        else if (ph < 6) e_addr = 15'(FB + k);
        else if (ph == 7) begin
          e_addr  = 15'(k);
          e_wren  = 1'b1;
          e_wdata = model_step(snap_b[k], snap_f[k]);
        end else if (CLR && ph == 8) begin
          e_addr = 15'(FB + k);
          e_wren = 1'b1;
        end
      end
      tests++;
      if (busy !== e_busy || done !== e_done || mem_addr !== e_addr ||
          mem_wren !== e_wren || mem_wdata !== e_wdata) begin
        fails++;
        $display("FAIL cycle t=%0d pass=%0d: busy/done/addr/wren/wdata got %b/%b/%0d/%b/%h expected %b/%b/%0d/%b/%h",
                 mt, pass_no, busy, done, mem_addr, mem_wren, mem_wdata,
                 e_busy, e_done, e_addr, e_wren, e_wdata);
      end
      if (pass_no == 1 && mrun && mt == 8) begin
        tests++;
        if (mem_wren !== 1'b1 || mem_addr !== 15'd0 ||
            mem_wdata !== {16'd101, 16'hffcd, 16'd26, 16'hfffe, 16'd7}) begin
          fails++;
          $display("FAIL first_write: wren=%b addr=%0d data=%h expected 1/0/%h",
                   mem_wren, mem_addr, mem_wdata,
                   {16'd101, 16'hffcd, 16'd26, 16'hfffe, 16'd7});
        end
      end
    end
  end

  task automatic run_pass(input bit poke);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
      start = poke && (n == 20);
    end
    start = 1'b0;
    tests++;
    if (n != 1 + P * N) begin
      fails++;
      $display("FAIL done_cycle: got %0d expected %0d", n, 1 + P * N);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [79:0] saved3;
    int          n;

    // Pin the reference model with hand-derived cases
    chk("model_basic", model_step(mk_body(100, -50, 16, 0, 7), mk_force(160, -32)),
        mk_body(101, -51, 26, -2, 7));
    chk("model_sat_pos", model_step(mk_body(32760, 0, 32000, 0, 1), mk_force(65536, 0)),
        mk_body(32767, 0, 32767, 0, 1));
    chk("model_sat_neg", model_step(mk_body(-32768, 0, -32000, 0, 1), mk_force(-65536, 0)),
        mk_body(-32768, 0, -32768, 0, 1));
    chk("model_floor_neg", model_step(mk_body(0, 0, 0, 0, 3), mk_force(-1, 0)),
        mk_body(-1, 0, -1, 0, 3));
    chk("model_floor_pos", model_step(mk_body(0, 0, 0, 0, 3), mk_force(15, 0)),
        mk_body(0, 0, 0, 0, 3));

    repeat (2) @(negedge clk);
    bd_write(0, mk_body(100, -50, 16, 0, 7));      bd_write(FB + 0, mk_force(160, -32));
    bd_write(1, mk_body(32760, 0, 32000, 0, 1));   bd_write(FB + 1, mk_force(65536, 0));
    bd_write(2, mk_body(-32768, 0, -32000, 0, 1)); bd_write(FB + 2, mk_force(-65536, 0));
    bd_write(3, mk_body(0, 0, 0, 0, 3));           bd_write(FB + 3, mk_force(-1, 0));
    bd_write(4, mk_body(0, 0, 0, 0, 3));           bd_write(FB + 4, mk_force(15, 0));
    for (int k = 5; k < N; k++) begin
      bd_write(k, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      if ($urandom_range(0, 3) == 0)
        bd_write(FB + k, mk_force(int'($urandom), int'($urandom)));
      else
        bd_write(FB + k, mk_force(int'($urandom_range(0, 4000)) - 2000,
                                  int'($urandom_range(0, 4000)) - 2000));
    end

    // Release reset; the compare process checks reset-state outputs from here
    checking = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Pass 1 from IDLE, with a start pulse while busy
    pass_no = 1;
    run_pass(1'b1);

    // Pass 2 from DONE, abandoned by reset in WAIT_FORCE of body 3
    pass_no = 2;
    saved3 = mem[3];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 1 + 3 * P + 4) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_write_body3", mem[3], saved3);

    // Pass 3 from IDLE after the abort
    pass_no = 3;
    run_pass(1'b0);

`ifndef INTEGRATOR_CLEAR_FORCE_EN
    for (int k = 0; k < N; k++)
      bd_write(FB + k, mk_force(int'($urandom_range(0, 60000)) - 30000,
                                int'($urandom)));
`endif
    // Pass 4 from DONE
    pass_no = 4;
    run_pass(1'b1);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
